// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: opcode values, default opcode width, assembler FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_OPP_WIDTH_DFLT = 2;

  localparam int OPP_SUM  = 0;
  localparam int OPP_MULT = 1;
  localparam int OPP_DIV  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GET_A = 2'd1,
    ST_GET_B = 2'd2,
    ST_ISSUE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_idle_timer.sv
// Idle-cycle counter for the frame timeout; flags when TIMEOUT_CYCLES-1 idle cycles have elapsed.
// Latency: o_expired is combinational from the count register.
// Backpressure: none; i_clr has priority over i_en.
// Ports: aclk/aresetn clock and sync active-low reset; i_clr zeroes the count; i_en counts one cycle;
//        o_expired high while the count sits at TIMEOUT_CYCLES-1.
module alu_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_cnt;

  // Saturates at LAST so a missed clear can never wrap into a false restart.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/alu_task_assembler.sv
// Assembles opcode + A + B ALU tasks from a byte stream (operands LSB-first) and holds each until accepted.
// Latency: task valid 1 clock after the last B byte is accepted.
// Backpressure: byte tready low while a task waits in ISSUE; task held until m_axis_a_tvalid & tready.
// Ports: aclk/aresetn clock and sync active-low reset; s_axis_byte_* incoming frame bytes;
//        m_alu_opp/m_axis_a_*/m_axis_b_tdata outgoing task (B qualified by A's valid);
//        o_frame_err pulse on a dropped bad opcode byte; o_timeout pulse on a discarded partial frame.
module alu_task_assembler
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ALU_OPP_WIDTH  = ALU_OPP_WIDTH_DFLT,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [7:0]               s_axis_byte_tdata,
  input  logic                     s_axis_byte_tvalid,
  output logic                     s_axis_byte_tready,
  output logic [ALU_OPP_WIDTH-1:0] m_alu_opp,
  output logic [DATA_WIDTH-1:0]    m_axis_a_tdata,
  output logic                     m_axis_a_tvalid,
  input  logic                     m_axis_a_tready,
  output logic [DATA_WIDTH-1:0]    m_axis_b_tdata,
  output logic                     o_frame_err,
  output logic                     o_timeout
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CW-1:0]            r_cnt;
  logic [ALU_OPP_WIDTH-1:0] r_opp;
  logic [DATA_WIDTH-1:0]    r_a;
  logic [DATA_WIDTH-1:0]    r_b;
  logic [ALU_OPP_WIDTH-1:0] r_out_opp;
  logic [DATA_WIDTH-1:0]    r_out_a;
  logic [DATA_WIDTH-1:0]    r_out_b;
  logic                     r_out_vld;
  logic                     r_frame_err;
  logic                     r_timeout;

  logic                     w_acc;
  logic                     w_op_ok;
  logic                     w_last;
  logic                     w_in_get;
  logic                     w_expired;
  logic                     w_timeout;
  logic                     w_hs;
  logic [DATA_WIDTH-1:0]    w_a_ins;
  logic [DATA_WIDTH-1:0]    w_b_ins;

  // Gated by reset so upstream never sees a handshake while we are held in reset.
  assign s_axis_byte_tready = aresetn & (r_state != ST_ISSUE);

  assign w_acc    = s_axis_byte_tvalid & s_axis_byte_tready;
  assign w_op_ok  = ((s_axis_byte_tdata >> ALU_OPP_WIDTH) == 8'd0) &&
                    (s_axis_byte_tdata <= 8'(OPP_DIV));
  assign w_last   = (r_cnt == CNT_LAST);
  assign w_in_get = (r_state == ST_GET_A) || (r_state == ST_GET_B);
  // An accepted byte on the expiry cycle keeps the frame alive.
  assign w_timeout = w_in_get & w_expired & ~w_acc;
  assign w_hs      = r_out_vld & m_axis_a_tready;

  // Timer only runs inside a frame; any accepted byte or leaving GET_* restarts it.
  alu_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_clr     (w_acc | ~w_in_get),
    .i_en      (w_in_get),
    .o_expired (w_expired)
  );

  // Current byte merged into its operand lane, indexed by the byte counter.
  always_comb begin
    w_a_ins = r_a;
    w_b_ins = r_b;
    w_a_ins[8*r_cnt +: 8] = s_axis_byte_tdata;
    w_b_ins[8*r_cnt +: 8] = s_axis_byte_tdata;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_acc && w_op_ok) w_state_nxt = ST_GET_A;
      end
      ST_GET_A: begin
        if (w_acc && w_last) w_state_nxt = ST_GET_B;
        else if (w_timeout)  w_state_nxt = ST_IDLE;
      end
      ST_GET_B: begin
        if (w_acc && w_last) w_state_nxt = ST_ISSUE;
        else if (w_timeout)  w_state_nxt = ST_IDLE;
      end
      ST_ISSUE: begin
        if (w_hs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_cnt       <= '0;
      r_opp       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out_opp   <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_vld   <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_frame_err <= (r_state == ST_IDLE) && w_acc && !w_op_ok;
      r_timeout   <= w_timeout;
      case (r_state)
        ST_IDLE: begin
          if (w_acc && w_op_ok) begin
            r_opp <= s_axis_byte_tdata[ALU_OPP_WIDTH-1:0];
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
          end
        end
        ST_GET_A: begin
          if (w_acc) begin
            r_a   <= w_a_ins;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          end else if (w_timeout) begin
            r_cnt <= '0;
          end
        end
        ST_GET_B: begin
          if (w_acc) begin
            r_b   <= w_b_ins;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            // Final B byte goes straight into the output register so valid rises next cycle.
            if (w_last) begin
              r_out_vld <= 1'b1;
              r_out_opp <= r_opp;
              r_out_a   <= r_a;
              r_out_b   <= w_b_ins;
            end
          end else if (w_timeout) begin
            r_cnt <= '0;
          end
        end
        ST_ISSUE: begin
          if (w_hs) r_out_vld <= 1'b0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign m_alu_opp       = r_out_opp;
  assign m_axis_a_tdata  = r_out_a;
  assign m_axis_b_tdata  = r_out_b;
  assign m_axis_a_tvalid = r_out_vld;
  assign o_frame_err     = r_frame_err;
  assign o_timeout       = r_timeout;

endmodule
